// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronized, debounced input pins with sticky
// rising-edge event flags, a per-channel interrupt mask and a level irq.
module mmio_input_port #(
    parameter int                CHANNELS        = 8,
    parameter int                DATA_W          = 16,
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter logic [DATA_W-1:0] BASE_ADDR       = 16'hFF00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_pins,
    input  logic [DATA_W-1:0]   addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

    logic [CHANNELS-1:0] sync1_r, sync2_r;
    logic [CHANNELS-1:0] level_r, level_nxt_s;
    logic [CHANNELS-1:0] event_r, event_nxt_s;
    logic [CHANNELS-1:0] mask_r;
    logic [CHANNELS-1:0] rise_s, clr_s;
    db_state_e           state_r   [CHANNELS];
    db_state_e           state_nxt_s [CHANNELS];
    logic [CW-1:0]       cnt_r     [CHANNELS];
    logic [CW-1:0]       cnt_nxt_s [CHANNELS];

    logic                hit_s, rd_hit_s, wr_hit_s;
    logic [1:0]          offset_s;
    logic [DATA_W-1:0]   rd_mux_s;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;

    // Two-flop synchronizer on the asynchronous pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {CHANNELS{1'b0}};
            sync2_r <= {CHANNELS{1'b0}};
        end else begin
            sync1_r <= in_pins;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM state, counters and debounced levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= {CHANNELS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= ST_STABLE;
                cnt_r[c]   <= CNT_ZERO;
            end
        end else begin
            level_r <= level_nxt_s;
            for (int c = 0; c < CHANNELS; c++) begin
                state_r[c] <= state_nxt_s[c];
                cnt_r[c]   <= cnt_nxt_s[c];
            end
        end
    end

    // Debounce next-state: the counter saturates at CNT_MAX by leaving COUNTING.
    always_comb begin
        level_nxt_s = level_r;
        for (int c = 0; c < CHANNELS; c++) begin
            state_nxt_s[c] = state_r[c];
            cnt_nxt_s[c]   = cnt_r[c];
            case (state_r[c])
                ST_STABLE: begin
                    if (sync2_r[c] != level_r[c]) begin
                        state_nxt_s[c] = ST_COUNTING;
                        cnt_nxt_s[c]   = CNT_ONE;
                    end else begin
                        cnt_nxt_s[c]   = CNT_ZERO;
                    end
                end
                ST_COUNTING: begin
                    if (sync2_r[c] == level_r[c]) begin
                        state_nxt_s[c] = ST_STABLE;
                        cnt_nxt_s[c]   = CNT_ZERO;
                    end else if (cnt_r[c] == CNT_MAX) begin
                        level_nxt_s[c] = sync2_r[c];
                        state_nxt_s[c] = ST_STABLE;
                        cnt_nxt_s[c]   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s[c]   = cnt_r[c] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s[c] = ST_STABLE;
                    cnt_nxt_s[c]   = CNT_ZERO;
                end
            endcase
        end
    end

    assign hit_s    = (addr[DATA_W-1:2] == BASE_ADDR[DATA_W-1:2]);
    assign offset_s = addr[1:0];
    assign rd_hit_s = rd_en & hit_s;
    assign wr_hit_s = wr_en & hit_s;

    // A same-cycle set overrides the write-1-to-clear.
    assign rise_s      = level_nxt_s & ~level_r;
    assign clr_s       = (wr_hit_s && (offset_s == 2'd1)) ? wr_data[CHANNELS-1:0] : {CHANNELS{1'b0}};
    assign event_nxt_s = (event_r & ~clr_s) | rise_s;

    // EVENT and MASK registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_r <= {CHANNELS{1'b0}};
            mask_r  <= {CHANNELS{1'b0}};
        end else begin
            event_r <= event_nxt_s;
            if (wr_hit_s && (offset_s == 2'd2)) begin
                mask_r <= wr_data[CHANNELS-1:0];
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Read mux over the pre-update register values.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        case (offset_s)
            2'd0:    rd_mux_s[CHANNELS-1:0] = level_r;
            2'd1:    rd_mux_s[CHANNELS-1:0] = event_r;
            2'd2:    rd_mux_s[CHANNELS-1:0] = mask_r;
            default: rd_mux_s = {DATA_W{1'b0}};
        endcase
    end

    // Registered read response; data holds its value on idle or missed reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_hit_s;
            if (rd_hit_s) begin
                rd_data_r <= rd_mux_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign irq      = |(event_r & mask_r);

endmodule

// File: tb/tb_mmio_input_port.sv
// Self-checking bench for mmio_input_port: a vector table for register decode
// plus hand-built sequences for debounce timing, interrupts, collisions and reset.
module tb_mmio_input_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_pins;
    logic [15:0] addr, wr_data, rd_data;
    logic        rd_en, wr_en, rd_valid, irq;

    mmio_input_port dut (
        .clk      (clk),
        .rst      (rst),
        .in_pins  (in_pins),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        string       nm;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[13];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_rd  = 16'h0000;

    localparam logic [15:0] A_STATUS = 16'hFF00;
    localparam logic [15:0] A_EVENT  = 16'hFF01;
    localparam logic [15:0] A_MASK   = 16'hFF02;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bus cycle, queue its expected response, compare once the edge has passed.
    task automatic bus_op(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] wd,
                          input logic ev, input logic [15:0] ed, input string nm);
        exp_t e;
        exp_t got;
        wr_en   = wr;
        rd_en   = rd;
        addr    = a;
        wr_data = wd;
        e.v = ev; e.d = ed; e.nm = nm;
        sb.push_back(e);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        got = sb.pop_front();
        check({got.nm, " rd_valid"}, {15'h0000, rd_valid}, {15'h0000, got.v});
        check({got.nm, " rd_data"}, rd_data, got.d);
        if (got.v) last_rd = got.d;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
        bus_op(1'b0, 1'b1, a, 16'h0000, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input string nm);
        bus_op(1'b1, 1'b0, a, d, 1'b0, last_rd, nm);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus_op(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, last_rd, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // wr, rd, addr, wdata, exp_valid, exp_data
        tbl[0]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, A_MASK,   16'hFFFF, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, A_MASK,   16'h0000, 1'b1, 16'h00FF};
        tbl[3]  = '{1'b0, 1'b1, 16'hFE01, 16'h0000, 1'b0, 16'h00FF};
        tbl[4]  = '{1'b1, 1'b0, 16'hFE02, 16'h0000, 1'b0, 16'h00FF};
        tbl[5]  = '{1'b0, 1'b1, A_MASK,   16'h0000, 1'b1, 16'h00FF};
        tbl[6]  = '{1'b1, 1'b0, A_STATUS, 16'hFFFF, 1'b0, 16'h00FF};
        tbl[7]  = '{1'b0, 1'b1, A_STATUS, 16'h0000, 1'b1, 16'h0000};
        tbl[8]  = '{1'b1, 1'b1, A_MASK,   16'h1234, 1'b1, 16'h00FF};
        tbl[9]  = '{1'b0, 1'b1, A_MASK,   16'h0000, 1'b1, 16'h0034};
        tbl[10] = '{1'b1, 1'b0, A_MASK,   16'h0000, 1'b0, 16'h0034};
        tbl[11] = '{1'b0, 1'b1, A_EVENT,  16'h0000, 1'b1, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

        rst = 1'b0; in_pins = 8'h00; addr = 16'h0000; wr_data = 16'h0000;
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_valid", {15'h0000, rd_valid}, 16'h0000);
        check("reset rd_data", rd_data, 16'h0000);
        check("reset irq", {15'h0000, irq}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++)
            bus_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].ev, tbl[i].ed,
                   $sformatf("vec%0d", i));
        check("irq masked off", {15'h0000, irq}, 16'h0000);

        // Clean edge on pin0: STATUS flips exactly at the 7th edge after the change.
        in_pins = 8'h01;
        for (int i = 1; i <= 8; i++)
            rd(A_STATUS, (i == 8) ? 16'h0001 : 16'h0000, $sformatf("latency rd%0d", i));
        rd(A_EVENT, 16'h0001, "latency event");

        // Three-cycle glitch on pin3 is rejected.
        in_pins = 8'h09;
        idle(3);
        in_pins = 8'h01;
        idle(10);
        rd(A_STATUS, 16'h0001, "glitch status");
        rd(A_EVENT, 16'h0001, "glitch event");

        // Masked pin2 raises irq on the debounce edge; W1C drops it.
        wr(A_MASK, 16'h0004, "irq mask wr");
        in_pins = 8'h05;
        for (int i = 1; i <= 7; i++) begin
            idle(1);
            if (i == 6) check("irq early", {15'h0000, irq}, 16'h0000);
            if (i == 7) check("irq set", {15'h0000, irq}, 16'h0001);
        end
        wr(A_EVENT, 16'h0004, "irq w1c");
        check("irq cleared", {15'h0000, irq}, 16'h0000);
        rd(A_EVENT, 16'h0001, "irq event");

        // Clear of bit5 lands on the same edge that sets it.
        in_pins = 8'h25;
        idle(6);
        wr(A_EVENT, 16'h0020, "collision w1c");
        rd(A_EVENT, 16'h0021, "collision event");
        wr(A_EVENT, 16'h00FF, "clear all");
        rd(A_EVENT, 16'h0000, "event cleared");
        rd(A_STATUS, 16'h0025, "status 0x25");

        // Reset mid-debounce with a read in flight.
        in_pins = 8'h65;
        idle(8);
        wr(A_MASK, 16'h0040, "mask bit6");
        check("irq before reset", {15'h0000, irq}, 16'h0001);
        in_pins = 8'h64;
        idle(4);
        rd_en = 1'b1; addr = A_EVENT; in_pins = 8'h00;
        #2 rst = 1'b0;
        #1;
        check("mid reset rd_valid", {15'h0000, rd_valid}, 16'h0000);
        check("mid reset rd_data", rd_data, 16'h0000);
        check("mid reset irq", {15'h0000, irq}, 16'h0000);
        rd_en = 1'b0;
        last_rd = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        tick();
        idle(10);
        check("post reset irq", {15'h0000, irq}, 16'h0000);
        rd(A_STATUS, 16'h0000, "post reset status");
        rd(A_EVENT, 16'h0000, "post reset event");
        rd(A_MASK, 16'h0000, "post reset mask");

        // Pin held high across reset release produces an event.
        in_pins = 8'h02;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        tick();
        idle(12);
        rd(A_EVENT, 16'h0002, "held pin event");
        rd(A_STATUS, 16'h0002, "held pin status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_input_port.md
MMIO_INPUT_PORT -- requirements
Module: mmio_input_port

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8, giving the number of external input pins; legal range 1..DATA_W.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the bus data and address width.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles needed to accept a new level; legal range >= 1.
REQ-004 The block SHALL have parameter BASE_ADDR, default 16'hFF00, giving the address of register offset 0; it must be 4-aligned.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_pins  input  CHANNELS  asynchronous external inputs (phone receiver lines).
REQ-008 addr  input  DATA_W  bus address from the load/store address mux.
REQ-009 rd_en  input  1  bus read strobe, one cycle per access.
REQ-010 wr_en  input  1  bus write strobe, one cycle per access.
REQ-011 wr_data  input  DATA_W  bus write data.
REQ-012 rd_data  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  high for exactly one cycle when rd_data holds a hit read result.
REQ-014 irq  output  1  level interrupt: OR of (EVENT & MASK).

Function
REQ-015 Address hit SHALL be addr[DATA_W-1:2] == BASE_ADDR[DATA_W-1:2]; offset = addr[1:0]; a miss SHALL be ignored for reads and writes.
REQ-016 Offset 0 STATUS (read-only) SHALL return the debounced level of each channel in bits [CHANNELS-1:0].
REQ-017 Offset 1 EVENT SHALL return sticky rising-edge flags; a write SHALL clear each bit where wr_data is 1 (write-1-to-clear).
REQ-018 Offset 2 MASK (read/write) SHALL hold the per-channel irq enable.
REQ-019 Offset 3 SHALL read as zero, and writes to it SHALL be ignored.
REQ-020 Unused bits [DATA_W-1:CHANNELS] SHALL read as zero, and writes to them SHALL be ignored.
REQ-021 Each in_pins bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-022 Each channel SHALL have a 2-state debounce FSM:
- STABLE: counter = 0; when the synchronized value differs from the debounced level, go to COUNTING with counter = 1.
- COUNTING: if the synchronized value returns to the debounced level, go to STABLE with counter = 0.
- Otherwise, when counter == DEBOUNCE_CYCLES, update the debounced level and go to STABLE.
- Otherwise, increment the counter.
REQ-023 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-024 A debounced 0->1 transition SHALL set the matching EVENT bit in the same cycle the debounced level updates.
REQ-025 Pin-to-STATUS latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
REQ-026 Read latency SHALL be 1 cycle: rd_en with a hit at edge N gives rd_data/rd_valid valid after edge N+1.
REQ-027 Reads with no hit and idle cycles SHALL give rd_valid = 0 and rd_data unchanged.
REQ-028 If an EVENT set and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win (bit stays 1).
REQ-029 A read of EVENT SHALL return the value before any same-cycle set; reads SHALL have no side effects.
REQ-030 If rd_en and wr_en are both high, the write SHALL take effect, and the read SHALL return the pre-write value.
REQ-031 irq SHALL be combinational from the EVENT and MASK registers, with no extra latency beyond the register update.

Reset
REQ-032 When rst is low, all of the following SHALL clear asynchronously to 0:
- synchronizer flops, debounced levels, debounce counters and FSM state (STABLE);
- EVENT and MASK;
- rd_data, rd_valid and irq.
REQ-033 Releasing reset with a pin held high SHALL produce an EVENT set after debounce, because the debounced level starts at 0.
REQ-034 Asserting reset mid-debounce or mid-read SHALL abort the operation; no rd_valid pulse SHALL follow reset release.

Verification
REQ-035 Defaults: drive in_pins = 8'h01 from idle -> STATUS reads 16'h0001, and EVENT bit0 = 1, 7 cycles after the pin change; no earlier.
REQ-036 Glitch: hold pin3 high for 3 cycles, then low (DEBOUNCE_CYCLES = 4) -> STATUS and EVENT stay 16'h0000.
REQ-037 Interrupt: write MASK = 16'h0004, then raise pin2 and debounce -> irq = 1; write EVENT = 16'h0004 -> irq = 0 the next cycle.
REQ-038 Collision: write-1-to-clear EVENT bit5 in the same cycle bit5 is set -> EVENT bit5 reads 1.
REQ-039 Decode: read addr 16'hFF03 -> rd_data = 0 with rd_valid = 1; read addr 16'hFE01 -> rd_valid = 0; write 16'hFFFF to MASK -> MASK reads 16'h00FF.
REQ-040 Reset: pull rst low while a channel is COUNTING and a read is pending -> all outputs are 0 immediately and stay 0 after release until new stimulus.
